// File: rtl/vote_pkg.sv
// Shared definitions for the ballot-entry path: key codes, keypad FSM states
// and the matrix position to key code mapping.
package vote_pkg;

  localparam logic [3:0] KEY_0       = 4'h0;
  localparam logic [3:0] KEY_1       = 4'h1;
  localparam logic [3:0] KEY_2       = 4'h2;
  localparam logic [3:0] KEY_3       = 4'h3;
  localparam logic [3:0] KEY_4       = 4'h4;
  localparam logic [3:0] KEY_5       = 4'h5;
  localparam logic [3:0] KEY_6       = 4'h6;
  localparam logic [3:0] KEY_7       = 4'h7;
  localparam logic [3:0] KEY_8       = 4'h8;
  localparam logic [3:0] KEY_9       = 4'h9;
  localparam logic [3:0] KEY_CANCEL  = 4'hA;
  localparam logic [3:0] KEY_CONFIRM = 4'hB;
  localparam logic [3:0] KEY_BLANK   = 4'hD;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    EMIT,
    WAIT_RELEASE
  } keypad_state_t;

  // Physical layout: rows top to bottom, columns left to right.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = KEY_1;
      4'b00_01: code = KEY_2;
      4'b00_10: code = KEY_3;
      4'b01_00: code = KEY_4;
      4'b01_01: code = KEY_5;
      4'b01_10: code = KEY_6;
      4'b10_00: code = KEY_7;
      4'b10_01: code = KEY_8;
      4'b10_10: code = KEY_9;
      4'b11_00: code = KEY_CANCEL;
      4'b11_01: code = KEY_0;
      4'b11_10: code = KEY_CONFIRM;
      default:  code = KEY_BLANK;
    endcase
    return code;
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] rows);
    logic [1:0] idx;
    case (rows)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [1:0] next_col(input logic [1:0] col);
    return (col == 2'd2) ? 2'd0 : col + 2'd1;
  endfunction

endpackage

// File: rtl/stable_counter.sv
// Counts consecutive qualifying clocks up to TARGET and saturates there;
// done stays high while the count sits at TARGET.
module stable_counter #(
  parameter int unsigned TARGET = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic match,
  output logic done
);

  localparam int unsigned CW = $clog2(TARGET + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TARGET);

  logic [CW-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (match && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == LIMIT);

endmodule

// File: rtl/keypad_encoder.sv
// Scans a 4x3 matrix keypad, debounces press and release, and emits one
// registered digit/valid pair per accepted key for the vote FSM.
module keypad_encoder
  import vote_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [2:0] cols,
  output logic [3:0] digit,
  output logic       valid,
  output logic       key_held,
  output logic       multi_key
);

  localparam int unsigned DW = $clog2(SCAN_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);

  keypad_state_t state, state_n;
  logic [DW-1:0] dwell, dwell_n;
  logic [1:0]    col_idx, col_n;
  logic [1:0]    row_idx, row_n;
  logic [3:0]    digit_n;
  logic          valid_n, held_n, multi_n;
  logic [3:0]    row_onehot;
  logic          press_done, release_done;

  assign row_onehot = 4'b0001 << row_idx;

  // Press side: consecutive clocks where the latched key alone is sensed.
  stable_counter #(.TARGET(DEBOUNCE_CYCLES)) u_press (
    .clock (clock),
    .reset (reset),
    .clear (state != DEBOUNCE),
    .match (rows == row_onehot),
    .done  (press_done)
  );

  // Release side: any activity on the driven column restarts the count.
  stable_counter #(.TARGET(DEBOUNCE_CYCLES)) u_release (
    .clock (clock),
    .reset (reset),
    .clear ((state != WAIT_RELEASE) || (rows != 4'b0000)),
    .match (rows == 4'b0000),
    .done  (release_done)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n = state;
    dwell_n = dwell;
    col_n   = col_idx;
    row_n   = row_idx;
    digit_n = digit;
    valid_n = 1'b0;
    multi_n = 1'b0;
    held_n  = key_held;

    case (state)
      SCAN: begin
        if (dwell == DWELL_LAST) begin
          dwell_n = '0;
          if (rows == 4'b0000) begin
            col_n = next_col(col_idx);
          end else if ($onehot(rows)) begin
            row_n   = row_index(rows);
            state_n = DEBOUNCE;
          end else begin
            multi_n = 1'b1;
            col_n   = next_col(col_idx);
          end
        end else begin
          dwell_n = dwell + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (press_done) begin
          state_n = EMIT;
          valid_n = 1'b1;
          digit_n = key_code(row_idx, col_idx);
          held_n  = 1'b1;
        end else if (rows != row_onehot) begin
          state_n = SCAN;
          col_n   = next_col(col_idx);
          dwell_n = '0;
        end
      end

      EMIT: begin
        state_n = WAIT_RELEASE;
      end

      WAIT_RELEASE: begin
        if (release_done) begin
          state_n = SCAN;
          col_n   = 2'd0;
          dwell_n = '0;
          held_n  = 1'b0;
        end
      end

      default: begin
        state_n = SCAN;
      end
    endcase
  end

  // Outputs are registered from their next values so they change with the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= SCAN;
      dwell     <= '0;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      cols      <= 3'b001;
      digit     <= KEY_BLANK;
      valid     <= 1'b0;
      key_held  <= 1'b0;
      multi_key <= 1'b0;
    end else begin
      state     <= state_n;
      dwell     <= dwell_n;
      col_idx   <= col_n;
      row_idx   <= row_n;
      cols      <= 3'b001 << col_n;
      digit     <= digit_n;
      valid     <= valid_n;
      key_held  <= held_n;
      multi_key <= multi_n;
    end
  end

endmodule

// File: tb/tb_keypad_encoder.sv
// Bench for keypad_encoder: a keypad model closes the row/column loop, and
// directed plus randomized presses are checked against a key-level model.
module tb_keypad_encoder;
  import vote_pkg::*;

  localparam int S = 2;
  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows;
  logic [2:0] cols;
  logic [3:0] digit;
  logic       valid, key_held, multi_key;

  logic [11:0] key_down = '0;  // bit r*3+c is key (row r, col c)

  int checks = 0;
  int passes = 0;
  int valid_count = 0;
  int multi_count = 0;
  logic [3:0] got_q[$];
  logic [3:0] exp_q[$];

  keypad_encoder #(.SCAN_CYCLES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clock     (clock),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .digit     (digit),
    .valid     (valid),
    .key_held  (key_held),
    .multi_key (multi_key)
  );

  always #5 clock = ~clock;

  // A pressed key shorts its column drive onto its row line.
  always_comb begin
    rows = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (key_down[r*3+c] && cols[c]) rows[r] = 1'b1;
  end

  always @(posedge clock) begin
    #1;
    if (valid === 1'b1) begin
      valid_count++;
      got_q.push_back(digit);
    end
    if (multi_key === 1'b1) multi_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [3:0] expected_code(input int r, input int c);
    if (r < 3) return 4'(r * 3 + c + 1);
    if (c == 0) return 4'hA;
    if (c == 1) return 4'h0;
    return 4'hB;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    valid_count = 0;
    multi_count = 0;
    got_q.delete();
  endtask

  task automatic wait_pulse(input int budget, output bit seen);
    int start;
    start = valid_count;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (valid_count != start) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    key_down = '0;
    reset = 1'b1;
    tick(2);
    checks++; if (cols !== 3'b001) $display("FAIL reset_cols: got %b expected 001", cols); else passes++;
    checks++; if (digit !== KEY_BLANK) $display("FAIL reset_digit: got %h expected d", digit); else passes++;
    checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid); else passes++;
    checks++; if (key_held !== 1'b0) $display("FAIL reset_key_held: got %b expected 0", key_held); else passes++;
    checks++; if (multi_key !== 1'b0) $display("FAIL reset_multi_key: got %b expected 0", multi_key); else passes++;
    reset = 1'b0;
    valid_count = 0;
    for (int n = 1; n <= 20; n++) begin
      logic [2:0] exp_cols;
      tick(1);
      exp_cols = 3'b001 << ((n / S) % 3);
      checks++;
      if (cols !== exp_cols) $display("FAIL idle_cols edge %0d: got %b expected %b", n, cols, exp_cols);
      else passes++;
    end
    checks++; if (valid_count !== 0) $display("FAIL idle_valid: got %0d pulses expected 0", valid_count); else passes++;
    checks++; if (digit !== KEY_BLANK) $display("FAIL idle_digit: got %h expected d", digit); else passes++;
  endtask

  task automatic test_single_press();
    key_down = '0;
    key_down[0] = 1'b1;
    apply_reset();
    tick(S + D);
    checks++; if (valid_count !== 0) $display("FAIL press_early: got %0d pulses expected 0", valid_count); else passes++;
    tick(1);
    checks++; if (valid !== 1'b1) $display("FAIL press_latency: got valid %b expected 1", valid); else passes++;
    checks++; if (digit !== expected_code(0, 0)) $display("FAIL press_digit: got %h expected %h", digit, expected_code(0, 0)); else passes++;
    checks++; if (key_held !== 1'b1) $display("FAIL press_held: got %b expected 1", key_held); else passes++;
    tick(1);
    checks++; if (valid !== 1'b0) $display("FAIL press_one_clock: got valid %b expected 0", valid); else passes++;
    tick(30 - (S + D + 2));
    checks++; if (valid_count !== 1) $display("FAIL press_no_repeat: got %0d pulses expected 1", valid_count); else passes++;
    checks++; if (key_held !== 1'b1) $display("FAIL press_hold: got %b expected 1", key_held); else passes++;
    key_down = '0;
    tick(D);
    checks++; if (key_held !== 1'b1) $display("FAIL release_early: got %b expected 1", key_held); else passes++;
    tick(1);
    checks++; if (key_held !== 1'b0) $display("FAIL release_done: got %b expected 0", key_held); else passes++;
    checks++; if (cols !== 3'b001) $display("FAIL release_col0: got %b expected 001", cols); else passes++;
  endtask

  task automatic test_sequence_03();
    bit seen;
    key_down = '0;
    key_down[3*3+1] = 1'b1;
    apply_reset();
    wait_pulse(40, seen);
    checks++; if (!seen) $display("FAIL seq_first_timeout: got no pulse expected one"); else passes++;
    checks++; if (digit !== expected_code(3, 1)) $display("FAIL seq_first_digit: got %h expected %h", digit, expected_code(3, 1)); else passes++;
    tick(15);
    checks++; if (valid_count !== 1) $display("FAIL seq_first_count: got %0d expected 1", valid_count); else passes++;
    key_down = '0;
    tick(D + 4);
    checks++; if (digit !== expected_code(3, 1)) $display("FAIL seq_digit_hold: got %h expected %h", digit, expected_code(3, 1)); else passes++;
    checks++; if (key_held !== 1'b0) $display("FAIL seq_released: got %b expected 0", key_held); else passes++;
    key_down[0*3+2] = 1'b1;
    wait_pulse(40, seen);
    checks++; if (!seen) $display("FAIL seq_second_timeout: got no pulse expected one"); else passes++;
    checks++; if (digit !== expected_code(0, 2)) $display("FAIL seq_second_digit: got %h expected %h", digit, expected_code(0, 2)); else passes++;
    tick(10);
    checks++; if (valid_count !== 2) $display("FAIL seq_total: got %0d expected 2", valid_count); else passes++;
    key_down = '0;
    tick(D + 3);
  endtask

  task automatic test_bounce();
    key_down = '0;
    key_down[0] = 1'b1;
    apply_reset();
    tick(S + 1);      // col0 sampled, one matching debounce clock
    key_down[0] = 1'b0;
    tick(1);          // mismatch: back to scanning at col1
    key_down[0] = 1'b1;
    tick(3 * S + D);
    checks++; if (valid_count !== 0) $display("FAIL bounce_no_pulse: got %0d pulses expected 0", valid_count); else passes++;
    tick(1);
    checks++; if (valid !== 1'b1) $display("FAIL bounce_latency: got valid %b expected 1", valid); else passes++;
    checks++; if (digit !== expected_code(0, 0)) $display("FAIL bounce_digit: got %h expected %h", digit, expected_code(0, 0)); else passes++;
    tick(20);
    checks++; if (valid_count !== 1) $display("FAIL bounce_count: got %0d expected 1", valid_count); else passes++;
    key_down = '0;
    tick(D + 3);
  endtask

  task automatic test_multi_key();
    key_down = '0;
    key_down[0] = 1'b1;
    key_down[3] = 1'b1;
    apply_reset();
    tick(S);
    checks++; if (multi_key !== 1'b1) $display("FAIL multi_pulse: got %b expected 1", multi_key); else passes++;
    tick(1);
    checks++; if (multi_key !== 1'b0) $display("FAIL multi_one_clock: got %b expected 0", multi_key); else passes++;
    tick(3 * 3 * S - 1);
    checks++; if (multi_count !== 4) $display("FAIL multi_count: got %0d expected 4", multi_count); else passes++;
    checks++; if (valid_count !== 0) $display("FAIL multi_no_valid: got %0d expected 0", valid_count); else passes++;
    key_down[3] = 1'b0;
    tick(3 * S + D);
    checks++; if (valid_count !== 0) $display("FAIL multi_release_early: got %0d expected 0", valid_count); else passes++;
    tick(1);
    checks++; if (valid !== 1'b1) $display("FAIL multi_release_valid: got %b expected 1", valid); else passes++;
    checks++; if (digit !== expected_code(0, 0)) $display("FAIL multi_release_digit: got %h expected %h", digit, expected_code(0, 0)); else passes++;
    key_down = '0;
    tick(D + 3);
  endtask

  task automatic test_reset_mid();
    key_down = '0;
    key_down[2*3+2] = 1'b1;
    apply_reset();
    tick(3 * S + D + 1);
    checks++; if (valid !== 1'b1) $display("FAIL mid_first_valid: got %b expected 1", valid); else passes++;
    tick(3);
    checks++; if (key_held !== 1'b1) $display("FAIL mid_waiting: got %b expected 1", key_held); else passes++;
    reset = 1'b1;
    tick(1);
    checks++; if (cols !== 3'b001) $display("FAIL mid_cols: got %b expected 001", cols); else passes++;
    checks++; if (digit !== KEY_BLANK) $display("FAIL mid_digit: got %h expected d", digit); else passes++;
    checks++; if (key_held !== 1'b0) $display("FAIL mid_key_held: got %b expected 0", key_held); else passes++;
    checks++; if (valid !== 1'b0) $display("FAIL mid_valid: got %b expected 0", valid); else passes++;
    reset = 1'b0;
    valid_count = 0;
    tick(3 * S + D);
    checks++; if (valid_count !== 0) $display("FAIL mid_early: got %0d expected 0", valid_count); else passes++;
    tick(1);
    checks++; if (valid !== 1'b1) $display("FAIL mid_reaccept: got %b expected 1", valid); else passes++;
    checks++; if (digit !== expected_code(2, 2)) $display("FAIL mid_reaccept_digit: got %h expected %h", digit, expected_code(2, 2)); else passes++;
    tick(20);
    checks++; if (valid_count !== 1) $display("FAIL mid_once: got %0d expected 1", valid_count); else passes++;
    key_down = '0;
    tick(D + 3);
  endtask

  task automatic test_random();
    int n_keys;
    n_keys = 12;
    key_down = '0;
    apply_reset();
    exp_q.delete();
    for (int i = 0; i < n_keys; i++) begin
      int r, c;
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 2);
      exp_q.push_back(expected_code(r, c));
      key_down[r*3+c] = 1'b1;
      tick(3 * S + D + 6 + $urandom_range(0, 8));
      checks++; if (key_held !== 1'b1) $display("FAIL rand_held %0d: got %b expected 1", i, key_held); else passes++;
      key_down = '0;
      tick(D + 2 + $urandom_range(0, 5));
      checks++; if (key_held !== 1'b0) $display("FAIL rand_release %0d: got %b expected 0", i, key_held); else passes++;
    end
    checks++;
    if (got_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d pulses expected %0d", got_q.size(), exp_q.size());
    else passes++;
    for (int i = 0; i < n_keys; i++) begin
      checks++;
      if (i >= got_q.size()) $display("FAIL rand_digit %0d: got none expected %h", i, exp_q[i]);
      else if (got_q[i] !== exp_q[i]) $display("FAIL rand_digit %0d: got %h expected %h", i, got_q[i], exp_q[i]);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_sequence_03();
    test_bounce();
    test_multi_key();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
